inst_fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the arithmetic/decode datapath. It owns the fetch PC, issues word reads to the instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small in-order prefetch queue. The datapath pops the queue through a valid/ready handshake, and a redirect input flushes the queue and restarts fetch at a new PC.

---
 rtl/inst_fetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time
// and buffers returned {pc, inst} pairs in an in-order prefetch queue.
//
// Ports:
//   clock, reset            clock; async active-high reset
//   mem_req/mem_addr        read request and word address (fetch_pc[31:2])
//   mem_gnt                 request accepted this cycle
//   mem_rvalid/mem_rdata    in-order read response
//   redirect/redirect_pc    flush the queue and restart at a new PC
//   inst_valid/inst/inst_pc queue head, popped when inst_ready is high
module inst_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          pending;
  logic          discard;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];

  logic grant;
  logic resp;
  logic push;
  logic pop;

  assign mem_req    = !pending && (count < CW'(DEPTH)) && !redirect;
  assign mem_addr   = fetch_pc[31:2];
  assign inst_valid = (count != '0);
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  assign grant = mem_req && mem_gnt;
  // A response with nothing outstanding is a protocol error: ignored.
  assign resp  = mem_rvalid && pending;
  assign push  = resp && !discard && !redirect;
  assign pop   = inst_valid && inst_ready && !redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      pending  <= 1'b0;
      discard  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'd3;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (resp) begin
        // The outstanding response drains now, so nothing is left to drop.
        pending <= 1'b0;
        discard <= 1'b0;
      end else if (pending) begin
        discard <= 1'b1;
      end
    end else begin
      if (grant) begin
        pending  <= 1'b1;
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp) begin
        pending <= 1'b0;
        if (discard) discard <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; entries are only read when counted valid.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= mem_rdata;
    end
  end

endmodule
